// File: rtl/seq_mult_ctrl_pkg.sv
// seq_mult_ctrl_pkg: shared state encoding and default sizing for the shift-add multiplier
package seq_mult_ctrl_pkg;
  localparam int N_DEF = 16;
  localparam int CW_DEF = 5;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_mult_ctrl_if.sv
// seq_mult_ctrl_if: operand request and product response handshakes of the multiplier
interface seq_mult_ctrl_if
  import seq_mult_ctrl_pkg::*;
#(
  parameter int N = N_DEF
);
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [2*N-1:0] product;
  modport master (
    output start, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );
  modport slave (
    input  start, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mult_ctrl_acc_sel_mux.sv
// acc_sel_mux: accumulator 2:1 select between pass-through and sum
module acc_sel_mux
  import seq_mult_ctrl_pkg::*;
#(
  parameter int W = N_DEF + 1
) (
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? data1 : data0;
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-add unsigned multiplier with ready/start and valid/ready handshakes
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_ctrl_if.slave bus,
  input  logic          abort,
  output logic          busy,
  output logic [CW-1:0] iter_cnt,
  output logic          mux_sel
);
  state_t state, state_nx;
  logic [N-1:0] a, acc, q;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] product;
  logic [N:0] sum, m;
  logic last;
  assign sum = {1'b0, acc} + {1'b0, a};
  assign last = cnt == CW'(N - 1);
  acc_sel_mux #(.W(N + 1)) u_mux (
    .data0(({1'b0, acc})),
    .data1(sum),
    .sel  (q[0]),
    .y    (m)
  );
  assign bus.in_ready = state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  assign bus.product = product;
  assign busy = state == ST_ITER;
  assign iter_cnt = cnt;
  assign mux_sel = busy ? q[0] : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = bus.start ? ST_ITER : ST_IDLE;
      ST_ITER: state_nx = abort ? ST_IDLE : last ? ST_DONE : ST_ITER;
      ST_DONE: state_nx = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end
  // product is latched only on the completing edge, so an abort leaves the old result visible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      acc <= '0;
      q <= '0;
      cnt <= '0;
      product <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      a <= bus.multiplicand;
      q <= bus.multiplier;
      acc <= '0;
      cnt <= '0;
    end else if (state == ST_ITER) begin
      acc <= m[N:1];
      q <= {m[0], q[N-1:1]};
      cnt <= cnt + 1'b1;
      if (last && !abort) product <= {m[N:1], m[0], q[N-1:1]};
    end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed self-checking bench for the sequential multiplier
module tb_seq_mult_ctrl;
  import seq_mult_ctrl_pkg::*;
  localparam int N = 16;
  localparam int CW = 5;
  logic clk = 0;
  logic rst_n = 1;
  logic abort = 0;
  logic busy, mux_sel;
  logic [CW-1:0] iter_cnt;
  int n_tests = 0;
  int n_fail = 0;
  seq_mult_ctrl_if #(.N(N)) bus ();
  seq_mult_ctrl #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .abort   (abort),
    .busy    (busy),
    .iter_cnt(iter_cnt),
    .mux_sel (mux_sel)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [N-1:0] x, input logic [N-1:0] y);
    bus.start = 1;
    bus.multiplicand = x;
    bus.multiplier = y;
    tick();
    bus.start = 0;
  endtask
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask
  task automatic run(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                     input logic [2*N-1:0] exp);
    int e;
    bus.out_ready = 1;
    accept(x, y);
    check({tag, "_mux_sel"}, 64'(mux_sel), 64'(y[0]));
    wait_valid(e);
    check({tag, "_latency"}, 64'(e), 64'd16);
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
    tick();
    check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask
  initial begin
    int e;
    logic bad;
    bus.start = 0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.out_ready = 0;
    rst_n = 0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    check("rst_mux_sel", 64'(mux_sel), 64'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    run("t1_3x5", 16'd3, 16'd5, 32'h0000_000F);
    run("t2_max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run("t2_zero", 16'h0000, 16'h1234, 32'h0000_0000);
    run("t2_shift", 16'h8000, 16'h0002, 32'h0001_0000);
    bus.out_ready = 1;
    accept(16'd3, 16'd5);
    e = 0;
    bad = 0;
    while (!bus.out_valid && e < 40) begin
      bus.start = (e == 4);
      bus.multiplicand = (e == 4) ? 16'd7 : 16'd3;
      bus.multiplier = (e == 4) ? 16'd9 : 16'd5;
      if (bus.in_ready || !busy) bad = 1;
      tick();
      e++;
    end
    bus.start = 0;
    check("t3_busy_no_ready", 64'(bad), 64'd0);
    check("t3_latency", 64'(e), 64'd16);
    check("t3_product", 64'(bus.product), 64'd15);
    tick();
    check("t3_in_ready_after", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 0;
    accept(16'h0012, 16'h0034);
    wait_valid(e);
    check("t4_product", 64'(bus.product), 64'h3A8);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.start = 1;
      bus.multiplicand = 16'd11;
      bus.multiplier = 16'd13;
      abort = i[0];
      if (!bus.out_valid || bus.product !== 32'h3A8 || bus.in_ready) bad = 1;
      tick();
    end
    bus.start = 0;
    abort = 0;
    check("t4_hold_stable", 64'(bad), 64'd0);
    check("t4_still_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1;
    tick();
    check("t4_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("t4_idle_out_valid", 64'(bus.out_valid), 64'd0);
    accept(16'h00FF, 16'h0101);
    repeat (7) tick();
    check("t5_iter_cnt", 64'(iter_cnt), 64'd7);
    abort = 1;
    tick();
    abort = 0;
    check("t5_abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_product_kept", 64'(bus.product), 64'h3A8);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) bad = 1;
      tick();
    end
    check("t5_no_valid", 64'(bad), 64'd0);
    abort = 1;
    accept(16'd7, 16'd9);
    abort = 0;
    check("t5_start_beats_abort", 64'(busy), 64'd1);
    wait_valid(e);
    check("t5_latency", 64'(e), 64'd16);
    check("t5_product", 64'(bus.product), 64'd63);
    tick();
    accept(16'd5, 16'd5);
    repeat (4) tick();
    #2;
    rst_n = 0;
    #1;
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_product", 64'(bus.product), 64'd0);
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1;
    tick();
    run("t6_2x3", 16'd2, 16'd3, 32'd6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
